ahbl_uart_loader: RTL and testbench

AHB-Lite initiator that takes a byte stream from a UART receiver and writes it into the on-chip RAM as 32-bit words, replacing the file-based program reload. Frame format: 4-byte little-endian word count N, then N words sent as 4 bytes each, least-significant byte first. The loader issues one single word write per assembled word, starting at BASE_ADDR with a 4-byte stride. It holds the CPU off via busy and reports done or error.

---
 rtl/ahbl_uart_loader.sv | 162 ++++++++++++++++
 tb/tb_ahbl_uart_loader.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_uart_loader.sv
// AHB-Lite initiator that loads a UART byte stream (LE word count, then LE words) into RAM.
// Each assembled word becomes one single NONSEQ word write at BASE_ADDR + 4*index.
module ahbl_uart_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h2000_0000,
    parameter int unsigned MAX_WORDS      = 16384,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] words_written
);

    typedef enum logic [2:0] {
        StIdle, StLen, StCollect, StAddr, StData, StDone, StErr
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] len_q, len_d;
    logic [31:0] word_q, word_d;
    logic [31:0] tmo_q, tmo_d;
    logic [15:0] ww_q, ww_d;
    logic        err_q, err_d;

    logic        byte_acc;
    logic [31:0] len_next;
    logic [15:0] ww_inc;
    logic        tmo_hit;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        word_d   = word_q;
        ww_d     = ww_q;
        err_d    = err_q;
        tmo_d    = '0;

        rx_ready = (state_q == StLen) || (state_q == StCollect);
        byte_acc = rx_ready && rx_valid;
        len_next = {rx_data, len_q[31:8]};
        ww_inc   = ww_q + 16'd1;
        tmo_hit  = (tmo_q == 32'(TIMEOUT_CYCLES - 1));

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLen;
                    err_d   = 1'b0;
                    ww_d    = '0;
                    idx_d   = '0;
                end
            end
            StLen: begin
                if (byte_acc) begin
                    len_d = len_next;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        if (len_next == 32'd0) begin
                            state_d = StDone;
                        end else if (len_next > 32'(MAX_WORDS)) begin
                            state_d = StErr;
                        end else begin
                            state_d = StCollect;
                        end
                    end
                end else if (tmo_hit) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StCollect: begin
                if (byte_acc) begin
                    word_d[8*idx_q +: 8] = rx_data;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = StAddr;
                    end
                end else if (tmo_hit) begin
                    // Partial word is simply dropped; nothing reaches the bus.
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            StAddr: begin
                if (HREADY) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (HREADY) begin
                    if (HRESP) begin
                        state_d = StErr;
                    end else begin
                        ww_d = ww_inc;
                        if ({16'd0, ww_inc} == len_q) begin
                            state_d = StDone;
                        end else begin
                            state_d = StCollect;
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d == StErr) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= StIdle;
            idx_q   <= '0;
            len_q   <= '0;
            word_q  <= '0;
            tmo_q   <= '0;
            ww_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            word_q  <= word_d;
            tmo_q   <= tmo_d;
            ww_q    <= ww_d;
            err_q   <= err_d;
        end
    end

    // ww_q counts completed writes, so it is also the index of the word in flight.
    assign HTRANS        = (state_q == StAddr) ? 2'b10 : 2'b00;
    assign HWRITE        = (state_q == StAddr);
    assign HADDR         = (state_q == StAddr) ? (BASE_ADDR + {14'd0, ww_q, 2'b00}) : 32'd0;
    assign HWDATA        = (state_q == StData) ? word_q : 32'd0;
    assign HSIZE         = 3'b010;
    assign busy          = (state_q == StLen) || (state_q == StCollect) || (state_q == StAddr) ||
                           (state_q == StData) || (state_q == StDone);
    assign done          = (state_q == StDone);
    assign error         = err_q;
    assign words_written = ww_q;

endmodule

// File: tb/tb_ahbl_uart_loader.sv
// Bench for ahbl_uart_loader: table-driven frames, random frames against a frame-level model,
// and hand-written timing sequences (latency, zero length, timeout, reset mid-frame).
module tb_ahbl_uart_loader;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int unsigned MAXW = 16384;
    localparam int unsigned TMO  = 64;

    logic        HCLK;
    logic        HRESET;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] words_written;

    ahbl_uart_loader #(
        .BASE_ADDR      (BASE),
        .MAX_WORDS      (MAXW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .start         (start),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HSIZE         (HSIZE),
        .HWRITE        (HWRITE),
        .HWDATA        (HWDATA),
        .HREADY        (HREADY),
        .HRESP         (HRESP),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Slave / bus monitor state
    int          ws_cfg     = 0;
    int          err_cfg    = -1;
    int          ph_cnt     = 0;
    bit          in_dp      = 0;
    logic [31:0] dp_addr    = '0;
    int          dp_idx     = 0;
    int          nonseq_cnt = 0;
    int          wr_cnt     = 0;
    int          done_cnt   = 0;
    int          stab_err   = 0;
    logic [31:0] mem [logic [31:0]];
    bit          prev_stall = 0;
    logic [1:0]  prev_htrans;
    logic [31:0] prev_haddr;
    logic [31:0] prev_hwdata;
    logic        prev_hwrite;

    // Slave decides HREADY/HRESP mid-cycle for the coming edge and records completed transfers.
    always @(negedge HCLK) begin
        if (HRESET) begin
            in_dp      = 0;
            ph_cnt     = 0;
            HREADY     = 1'b1;
            HRESP      = 1'b0;
            prev_stall = 0;
        end else begin
            if (prev_stall && (HTRANS !== prev_htrans || HADDR !== prev_haddr ||
                               HWDATA !== prev_hwdata || HWRITE !== prev_hwrite)) begin
                stab_err++;
            end
            if (done) done_cnt++;
            HRESP = 1'b0;
            if (HTRANS == 2'b10 || in_dp) begin
                if (ph_cnt < ws_cfg) begin
                    HREADY = 1'b0;
                    ph_cnt++;
                end else begin
                    HREADY = 1'b1;
                    ph_cnt = 0;
                end
            end else begin
                HREADY = 1'b1;
                ph_cnt = 0;
            end
            if (!HREADY && rx_ready) stab_err++;
            if (HREADY) begin
                if (in_dp) begin
                    if (dp_idx == err_cfg) begin
                        HRESP = 1'b1;
                    end else begin
                        mem[dp_addr] = HWDATA;
                        wr_cnt++;
                    end
                    dp_idx++;
                    in_dp = 0;
                end else if (HTRANS == 2'b10) begin
                    dp_addr = HADDR;
                    in_dp   = 1;
                    nonseq_cnt++;
                end
            end
            prev_stall  = !HREADY;
            prev_htrans = HTRANS;
            prev_haddr  = HADDR;
            prev_hwdata = HWDATA;
            prev_hwrite = HWRITE;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] wq [$];

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic clear_mon(input int ws, input int err_idx);
        ws_cfg     = ws;
        err_cfg    = err_idx;
        done_cnt   = 0;
        wr_cnt     = 0;
        nonseq_cnt = 0;
        dp_idx     = 0;
        stab_err   = 0;
        mem.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called and returns at #1 after an edge; rx_ready is stable then.
    task automatic send_byte(input logic [7:0] b);
        bit ok  = 0;
        bit acc;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int g = 0; g < 40 && !ok; g++) begin
            acc = rx_ready;
            tick();
            if (acc) ok = 1;
        end
        rx_valid = 1'b0;
        chk("rx_accept", 32'(ok), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8]);
    endtask

    task automatic fill_fixed(input int n);
        wq.delete();
        for (int i = 0; i < n; i++) begin
            if (i == 0)      wq.push_back(32'h1122_3344);
            else if (i == 1) wq.push_back(32'h5566_7788);
            else             wq.push_back({8'(i), 8'hA5, 8'(i * 3), 8'h5A});
        end
    endtask

    task automatic run_frame(input string name, input logic [31:0] len, input int ws,
                             input int err_idx, input bit exp_err, input int exp_done,
                             input int exp_ww, input int exp_wr);
        int sent;
        bit idle;
        sent = exp_err ? ((len > MAXW) ? 0 : exp_ww + 1) : int'(len);
        clear_mon(ws, err_idx);
        pulse_start();
        send_word(len);
        for (int w = 0; w < sent; w++) begin
            for (int b = 0; b < 4; b++) begin
                logic [31:0] word;
                word = wq[w];
                send_byte(word[8*b +: 8]);
                repeat ($urandom_range(0, 2)) tick();
            end
        end
        idle = 0;
        for (int c = 0; c < 100 && !idle; c++) begin
            if (!busy) idle = 1;
            else tick();
        end
        chk({name, "_busy_clear"}, 32'(idle), 32'd1);
        tick();
        tick();
        chk({name, "_error"}, 32'(error), 32'(exp_err));
        chk({name, "_done_cnt"}, done_cnt, exp_done);
        chk({name, "_words_written"}, 32'(words_written), exp_ww);
        chk({name, "_writes"}, wr_cnt, exp_wr);
        chk({name, "_nonseq"}, nonseq_cnt, exp_err ? sent : exp_wr);
        chk({name, "_stable"}, stab_err, 0);
        for (int i = 0; i < exp_wr; i++) begin
            logic [31:0] a;
            a = BASE + 32'(4 * i);
            chk({name, "_ram"}, mem.exists(a) ? mem[a] : 32'hxxxx_xxxx, wq[i]);
        end
    endtask

    typedef struct {
        logic [31:0] len;
        int          ws;
        int          err_idx;
        bit          exp_err;
        int          exp_done;
        int          exp_ww;
        int          exp_wr;
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{len: 32'd2,      ws: 0, err_idx: -1, exp_err: 0, exp_done: 1, exp_ww: 2, exp_wr: 2};
        vecs[1] = '{len: 32'd2,      ws: 3, err_idx: -1, exp_err: 0, exp_done: 1, exp_ww: 2, exp_wr: 2};
        vecs[2] = '{len: 32'd3,      ws: 1, err_idx: -1, exp_err: 0, exp_done: 1, exp_ww: 3, exp_wr: 3};
        vecs[3] = '{len: 32'd0,      ws: 0, err_idx: -1, exp_err: 0, exp_done: 1, exp_ww: 0, exp_wr: 0};
        vecs[4] = '{len: 32'd2,      ws: 0, err_idx: 0,  exp_err: 1, exp_done: 0, exp_ww: 0, exp_wr: 0};
        vecs[5] = '{len: 32'd3,      ws: 2, err_idx: 1,  exp_err: 1, exp_done: 0, exp_ww: 1, exp_wr: 1};
        vecs[6] = '{len: 32'h4001,   ws: 0, err_idx: -1, exp_err: 1, exp_done: 0, exp_ww: 0, exp_wr: 0};

        HRESET   = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) tick();
        chk("rst_htrans", 32'(HTRANS), 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwrite", 32'(HWRITE), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_hsize", 32'(HSIZE), 32'd2);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_words", 32'(words_written), 32'd0);
        HRESET = 1'b0;
        tick();

        // Single word: address phase right after the 4th byte, data phase next, then done.
        clear_mon(0, -1);
        pulse_start();
        chk("lat_busy", 32'(busy), 32'd1);
        send_word(32'd1);
        send_word(32'hDEAD_BEEF);
        chk("lat_htrans_addr", 32'(HTRANS), 32'd2);
        chk("lat_hwrite_addr", 32'(HWRITE), 32'd1);
        chk("lat_haddr", HADDR, BASE);
        chk("lat_rx_ready", 32'(rx_ready), 32'd0);
        tick();
        chk("lat_htrans_data", 32'(HTRANS), 32'd0);
        chk("lat_hwrite_data", 32'(HWRITE), 32'd0);
        chk("lat_hwdata", HWDATA, 32'hDEAD_BEEF);
        tick();
        chk("lat_done", 32'(done), 32'd1);
        tick();
        chk("lat_done_off", 32'(done), 32'd0);
        chk("lat_busy_off", 32'(busy), 32'd0);

        // Zero length: done the cycle after the 4th count byte, no bus traffic.
        clear_mon(0, -1);
        pulse_start();
        send_word(32'd0);
        chk("zero_done", 32'(done), 32'd1);
        tick();
        chk("zero_done_off", 32'(done), 32'd0);
        chk("zero_busy_off", 32'(busy), 32'd0);
        chk("zero_nonseq", nonseq_cnt, 0);

        foreach (vecs[i]) begin
            fill_fixed(int'(vecs[i].len > MAXW ? 0 : vecs[i].len));
            run_frame($sformatf("vec%0d", i), vecs[i].len, vecs[i].ws, vecs[i].err_idx,
                      vecs[i].exp_err, vecs[i].exp_done, vecs[i].exp_ww, vecs[i].exp_wr);
        end

        // Error stays set until the next accepted start, which clears it.
        repeat (5) tick();
        chk("sticky_error", 32'(error), 32'd1);

        // Timeout after two data bytes: no write, error raised after TMO idle cycles.
        clear_mon(0, -1);
        pulse_start();
        chk("start_clears_error", 32'(error), 32'd0);
        send_word(32'd1);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TMO - 3) tick();
        chk("tmo_not_yet", 32'(error), 32'd0);
        begin
            bit hit = 0;
            for (int c = 0; c < 10 && !hit; c++) begin
                if (error) hit = 1;
                else tick();
            end
            chk("tmo_error", 32'(hit), 32'd1);
        end
        tick();
        chk("tmo_nonseq", nonseq_cnt, 0);
        chk("tmo_writes", wr_cnt, 0);
        chk("tmo_busy", 32'(busy), 32'd0);

        // Reset while the first data phase is stalled, then a clean reload.
        fill_fixed(2);
        clear_mon(3, -1);
        pulse_start();
        send_word(32'd2);
        send_word(wq[0]);
        begin
            bit got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                if (in_dp) got = 1;
                else tick();
            end
            chk("rstmid_reach_data", 32'(got), 32'd1);
        end
        chk("rstmid_hwdata", HWDATA, wq[0]);
        HRESET = 1'b1;
        tick();
        chk("rstmid_htrans", 32'(HTRANS), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_hwdata_clr", HWDATA, 32'd0);
        chk("rstmid_words", 32'(words_written), 32'd0);
        HRESET = 1'b0;
        tick();
        run_frame("after_rst", 32'd2, 0, -1, 0, 1, 2, 2);

        // Random frames checked against a frame-level model.
        for (int r = 0; r < 10; r++) begin
            logic [31:0] len;
            int          ws, eidx, e_ww, e_wr, e_done;
            bit          e_err;
            len  = 32'($urandom_range(1, 5));
            if ($urandom_range(0, 5) == 0) len = MAXW + 1 + $urandom_range(0, 1000);
            ws   = $urandom_range(0, 2);
            eidx = -1;
            if (len <= MAXW && $urandom_range(0, 3) == 0) eidx = $urandom_range(0, int'(len) - 1);
            wq.delete();
            if (len <= MAXW) for (int i = 0; i < int'(len); i++) wq.push_back($urandom);
            if (len > MAXW) begin
                e_err = 1; e_done = 0; e_ww = 0; e_wr = 0;
            end else if (eidx >= 0) begin
                e_err = 1; e_done = 0; e_ww = eidx; e_wr = eidx;
            end else begin
                e_err = 0; e_done = 1; e_ww = int'(len); e_wr = int'(len);
            end
            run_frame($sformatf("rnd%0d", r), len, ws, eidx, e_err, e_done, e_ww, e_wr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
